// File: rtl/flag_gen_stage_pkg.sv
// Shared definitions for the execute-stage flag generator: op codes,
// branch codes (same encoding the branch-condition evaluator decodes)
// and the condition-flag bundle.
package flag_gen_stage_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned BR_W   = 3;

   // Operation codes
   localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
   localparam logic [OP_W-1:0] OP_AND    = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR    = 3'd3;
   localparam logic [OP_W-1:0] OP_PASS_A = 3'd4;
   localparam logic [OP_W-1:0] OP_ADDC   = 3'd5;

   // Branch codes
   localparam logic [BR_W-1:0] BR_NONE = 3'd0;
   localparam logic [BR_W-1:0] BR_JUMP = 3'd1;
   localparam logic [BR_W-1:0] BR_BEQZ = 3'd2;
   localparam logic [BR_W-1:0] BR_BNEZ = 3'd3;
   localparam logic [BR_W-1:0] BR_BLTZ = 3'd4;
   localparam logic [BR_W-1:0] BR_BGEZ = 3'd5;
   localparam logic [BR_W-1:0] BR_BSCO = 3'd6;

   typedef struct packed {
      logic sf;
      logic zf;
      logic of;
      logic cf;
   } flags_t;

endpackage

// File: rtl/flag_alu.sv
// Combinational ALU producing a DW-bit result plus SF/ZF/OF/CF.
// Ports: op (op code), a/b (operands), cin (carry for ADDC),
//        r (result), flags (sf, zf, of, cf).
module flag_alu
   import flag_gen_stage_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic [OP_W-1:0] op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            cin,
   output logic [DW-1:0]   r,
   output flags_t          flags
);

   localparam int unsigned SW = DW + 1;

   logic [DW-1:0] b_eff;
   logic          c_eff;
   logic [DW:0]   sum;

   // One shared adder: SUB is a + ~b + 1, ADDC folds in the carry input
   always_comb begin
      b_eff = b;
      c_eff = 1'b0;
      if (op == OP_SUB) begin
         b_eff = ~b;
         c_eff = 1'b1;
      end else if (op == OP_ADDC) begin
         c_eff = cin;
      end
   end

   assign sum = SW'(a) + SW'(b_eff) + SW'(c_eff);

   // Result and flag selection
   always_comb begin
      r        = '0;
      flags.cf = 1'b0;
      flags.of = 1'b0;
      case (op)
         OP_ADD, OP_ADDC: begin
            r        = sum[DW-1:0];
            flags.cf = sum[DW];
            flags.of = (a[DW-1] == b[DW-1]) & (sum[DW-1] != a[DW-1]);
         end
         OP_SUB: begin
            r        = sum[DW-1:0];
            flags.cf = sum[DW];
            flags.of = (a[DW-1] != b[DW-1]) & (sum[DW-1] != a[DW-1]);
         end
         OP_AND:    r = a & b;
         OP_XOR:    r = a ^ b;
         OP_PASS_A: r = a;
         default:   r = '0;
      endcase
      flags.sf = r[DW-1];
      flags.zf = (r == '0);
   end

endmodule

// File: rtl/flag_gen_stage.sv
// Execute stage: one valid/ready slot holding ALU result, flags and branch
// code, plus the architectural flag register updated on slot transfer.
// Ports: in_valid/in_ready, op, a, b, flag_we, branch_in, flush (upstream);
//        out_valid/out_ready, result, sf/zf/of/cf, branch_out (downstream);
//        arch_sf/zf/of/cf (architectural flags).
// Optional FLAG_STICKY_OVF_EN adds ovf_clr (in) and ovf_sticky (out).
module flag_gen_stage
   import flag_gen_stage_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            flag_we,
   input  logic [BR_W-1:0] branch_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   result,
   output logic            sf,
   output logic            zf,
   output logic            of,
   output logic            cf,
   output logic [BR_W-1:0] branch_out,
   output logic            arch_sf,
   output logic            arch_zf,
   output logic            arch_of,
   output logic            arch_cf
`ifdef FLAG_STICKY_OVF_EN
   ,
   input  logic            ovf_clr,
   output logic            ovf_sticky
`endif
);

   logic            valid_q,  valid_d;
   logic [DW-1:0]   result_q, result_d;
   flags_t          flags_q,  flags_d;
   logic [BR_W-1:0] branch_q, branch_d;
   logic            fwe_q,    fwe_d;
   flags_t          arch_q,   arch_d;

   logic [DW-1:0]   alu_r;
   flags_t          alu_flags;
   logic            accept;
   logic            xfer;
   logic            arch_upd;

   flag_alu #(.DW(DW)) u_alu (
      .op    (op),
      .a     (a),
      .b     (b),
      .cin   (arch_q.cf),
      .r     (alu_r),
      .flags (alu_flags)
   );

   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign xfer     = valid_q & out_ready;
   // A slot killed by flush must not leave its flags behind
   assign arch_upd = xfer & fwe_q & ~flush;

   // Slot and architectural register next-state
   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      flags_d  = flags_q;
      branch_d = branch_q;
      fwe_d    = fwe_q;
      arch_d   = arch_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         result_d = alu_r;
         flags_d  = alu_flags;
         branch_d = branch_in;
         fwe_d    = flag_we;
      end else if (xfer) begin
         valid_d = 1'b0;
      end

      if (arch_upd) begin
         arch_d = flags_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         branch_q <= BR_NONE;
         fwe_q    <= 1'b0;
         arch_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         branch_q <= branch_d;
         fwe_q    <= fwe_d;
         arch_q   <= arch_d;
      end
   end

   assign out_valid  = valid_q;
   assign result     = result_q;
   assign sf         = flags_q.sf;
   assign zf         = flags_q.zf;
   assign of         = flags_q.of;
   assign cf         = flags_q.cf;
   assign branch_out = branch_q;
   assign arch_sf    = arch_q.sf;
   assign arch_zf    = arch_q.zf;
   assign arch_of    = arch_q.of;
   assign arch_cf    = arch_q.cf;

`ifdef FLAG_STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // Set wins over a same-cycle clear
   always_comb begin
      sticky_d = sticky_q;
      if (arch_upd & flags_q.of) begin
         sticky_d = 1'b1;
      end else if (ovf_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_flag_gen_stage.sv
// Directed self-checking bench for flag_gen_stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_flag_gen_stage;
   import flag_gen_stage_pkg::*;

   localparam int unsigned DW = 16;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] op;
   logic [DW-1:0]   a;
   logic [DW-1:0]   b;
   logic            flag_we;
   logic [BR_W-1:0] branch_in;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   result;
   logic            sf, zf, of, cf;
   logic [BR_W-1:0] branch_out;
   logic            arch_sf, arch_zf, arch_of, arch_cf;
`ifdef FLAG_STICKY_OVF_EN
   logic            ovf_clr;
   logic            ovf_sticky;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   flag_gen_stage #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .flag_we    (flag_we),
      .branch_in  (branch_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .sf         (sf),
      .zf         (zf),
      .of         (of),
      .cf         (cf),
      .branch_out (branch_out),
      .arch_sf    (arch_sf),
      .arch_zf    (arch_zf),
      .arch_of    (arch_of),
      .arch_cf    (arch_cf)
`ifdef FLAG_STICKY_OVF_EN
      ,
      .ovf_clr    (ovf_clr),
      .ovf_sticky (ovf_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] slot_flags();
      return {sf, zf, of, cf};
   endfunction

   function automatic logic [3:0] arch_flags();
      return {arch_sf, arch_zf, arch_of, arch_cf};
   endfunction

   // Present one op for one cycle; returns just after the loading edge
   task automatic issue(input logic [OP_W-1:0] o, input logic [DW-1:0] va,
                        input logic [DW-1:0] vb, input logic we, input logic [BR_W-1:0] br);
      in_valid  = 1'b1;
      op        = o;
      a         = va;
      b         = vb;
      flag_we   = we;
      branch_in = br;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   // Stream table: op, a, b, we, expected result, expected {sf,zf,of,cf}
   logic [OP_W-1:0] s_op  [4] = '{OP_AND, OP_XOR, OP_PASS_A, OP_ADD};
   logic [DW-1:0]   s_a   [4] = '{16'hF0F0, 16'hAAAA, 16'h8001, 16'hFFFF};
   logic [DW-1:0]   s_b   [4] = '{16'h0FF0, 16'hAAAA, 16'h1234, 16'h0001};
   logic            s_we  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [DW-1:0]   s_r   [4] = '{16'h00F0, 16'h0000, 16'h8001, 16'h0000};
   logic [3:0]      s_f   [4] = '{4'b0000, 4'b0100, 4'b1000, 4'b0101};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = OP_ADD;
      a         = '0;
      b         = '0;
      flag_we   = 1'b0;
      branch_in = BR_NONE;
      flush     = 1'b0;
      out_ready = 1'b1;
`ifdef FLAG_STICKY_OVF_EN
      ovf_clr   = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'(slot_flags()), 32'd0);
      check("rst_branch", 32'(branch_out), 32'(BR_NONE));
      check("rst_arch", 32'(arch_flags()), 32'd0);
`ifdef FLAG_STICKY_OVF_EN
      check("rst_sticky", 32'(ovf_sticky), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Signed overflow on ADD
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, BR_JUMP);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_result", 32'(result), 32'h8000);
      check("add_flags", 32'(slot_flags()), 32'b1010);
      check("add_branch", 32'(branch_out), 32'(BR_JUMP));
      check("add_arch_before", 32'(arch_flags()), 32'd0);
      @(negedge clk);
      check("add_drained", 32'(out_valid), 32'd0);
      check("add_arch_of", 32'(arch_of), 32'd1);
      check("add_arch", 32'(arch_flags()), 32'b1010);
`ifdef FLAG_STICKY_OVF_EN
      check("sticky_set", 32'(ovf_sticky), 32'd1);
`endif

      // SUB equal operands, then SUB with borrow
      issue(OP_SUB, 16'h0005, 16'h0005, 1'b1, BR_BEQZ);
      check("sub0_result", 32'(result), 32'h0000);
      check("sub0_flags", 32'(slot_flags()), 32'b0101);
      check("sub0_branch", 32'(branch_out), 32'(BR_BEQZ));
      issue(OP_SUB, 16'h0003, 16'h0005, 1'b0, BR_BLTZ);
      check("sub1_result", 32'(result), 32'hFFFE);
      check("sub1_flags", 32'(slot_flags()), 32'b1000);
      check("sub0_arch", 32'(arch_flags()), 32'b0101);
      @(negedge clk);
      check("sub1_no_arch", 32'(arch_flags()), 32'b0101);
`ifdef FLAG_STICKY_OVF_EN
      check("sticky_hold", 32'(ovf_sticky), 32'd1);
`endif

      // Undefined op code
      issue(3'd7, 16'h1234, 16'h5678, 1'b0, BR_BSCO);
      check("undef_result", 32'(result), 32'h0000);
      check("undef_flags", 32'(slot_flags()), 32'b0100);
      check("undef_branch", 32'(branch_out), 32'(BR_BSCO));
      @(negedge clk);

      // Back-to-back stream
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         op        = s_op[i];
         a         = s_a[i];
         b         = s_b[i];
         flag_we   = s_we[i];
         branch_in = BR_BGEZ;
         #1;
         check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
         @(negedge clk);
         check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("stream_result_%0d", i), 32'(result), 32'(s_r[i]));
         check($sformatf("stream_flags_%0d", i), 32'(slot_flags()), 32'(s_f[i]));
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_arch", 32'(arch_flags()), 32'b0101);

      // Stall: slot holds while downstream is not ready
      out_ready = 1'b0;
      issue(OP_XOR, 16'h1234, 16'h00FF, 1'b0, BR_BLTZ);
      in_valid = 1'b1;
      op       = OP_ADD;
      a        = 16'h0001;
      b        = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall_ready_%0d", i), 32'(in_ready), 32'd0);
         @(negedge clk);
         check($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("stall_result_%0d", i), 32'(result), 32'h12CB);
         check($sformatf("stall_branch_%0d", i), 32'(branch_out), 32'(BR_BLTZ));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_drained", 32'(out_valid), 32'd0);

      // ADDC with carry from the architectural register
      issue(OP_ADDC, 16'hFFFF, 16'h0000, 1'b1, BR_NONE);
      check("addc_result", 32'(result), 32'h0000);
      check("addc_flags", 32'(slot_flags()), 32'b0101);
      @(negedge clk);
      check("addc_arch", 32'(arch_flags()), 32'b0101);

      // Flush beats a same-cycle accept
      flush = 1'b1;
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, BR_JUMP);
      flush = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("flush_arch", 32'(arch_flags()), 32'b0101);

`ifdef FLAG_STICKY_OVF_EN
      // Sticky clear, then set colliding with clear
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("sticky_clr", 32'(ovf_sticky), 32'd0);
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, BR_NONE);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("sticky_set_wins", 32'(ovf_sticky), 32'd1);
`endif

      // Reset during a stall drops the slot at once
      out_ready = 1'b0;
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, BR_JUMP);
      check("mid_stall_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_arch", 32'(arch_flags()), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_arch", 32'(arch_flags()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/flag_gen_stage.md
Name: flag_gen_stage

Overview:
- Execute-stage producer of the condition flags (SF, ZF, OF, CF) and the 3-bit branch code consumed by the branch-condition evaluator.
- Performs 16-bit ALU arithmetic and registers result, flags and branch code into one valid/ready pipeline slot.
- Also maintains the architectural flag register that later instructions read.
- Sits between decode/operand-fetch and the branch-condition / memory stage.

Parameters:
- DW, 16, datapath width in bits; flags are derived from bit DW-1 and the DW-bit result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  this stage accepts the operation this cycle.
- op  in  3  operation code (package constants).
- a, b  in  DW each  operands.
- flag_we  in  1  this operation updates the architectural flags.
- branch_in  in  3  branch code carried alongside the operation.
- flush  in  1  kill the pipeline slot.
- out_valid  out  1  slot holds a valid result.
- out_ready  in  1  downstream consumes the slot.
- result  out  DW  registered ALU result.
- sf, zf, of, cf  out  1 each  registered flags of the slot's operation.
- branch_out  out  3  registered branch code.
- arch_sf, arch_zf, arch_of, arch_cf  out  1 each  architectural flag register.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, result=0, sf=zf=of=cf=0, branch_out=0 (NONE), all arch_* flags=0. in_ready follows its equation, so it is 1.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready; the slot loads on the next rising edge, giving 1-cycle latency.
  - Output transfer occurs when out_valid & out_ready.
  - Accept and transfer in the same cycle: the slot reloads and out_valid stays 1.
  - Transfer with no accept: out_valid clears.
- Stall: with out_valid=1 and out_ready=0, all slot outputs hold stable and in_ready=0.
- Flush: takes priority over accept. The next edge gives out_valid=0; data fields are don't-care. A flushed slot never updates the arch flags.
- Arch flag update: on an output transfer whose captured flag_we=1, arch_* takes sf/zf/of/cf at that edge. The ADDC op reads arch_cf as of its issue cycle.
- Ops, with r = result:
  - ADD: {cf,r} = a+b; of = (a[DW-1]==b[DW-1]) & (r[DW-1]!=a[DW-1]).
  - SUB: r = a+~b+1; cf = carry-out (1 = no borrow); of = (a[DW-1]!=b[DW-1]) & (r[DW-1]!=a[DW-1]).
  - ADDC: {cf,r} = a+b+arch_cf; of as for ADD.
  - AND, XOR, PASS_A: cf=0, of=0.
  - Undefined codes: r=0, cf=of=0.
  - All ops: sf = r[DW-1]; zf = (r==0). Results wrap modulo 2^DW.
- Branch codes pass through unmodified with the slot.
- Reset asserted mid-stall drops the slot immediately; no arch update occurs.

Optional Feature:
- Macro: FLAG_STICKY_OVF_EN.
- When defined:
  - Adds ports ovf_sticky (out, 1) and ovf_clr (in, 1).
  - ovf_sticky sets on any arch flag update with of=1 and clears on ovf_clr.
  - If set and clear occur in the same cycle, set wins.
  - Reset value is 0.
- When undefined: the ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - op codes: ADD=0, SUB=1, AND=2, XOR=3, PASS_A=4, ADDC=5.
  - branch codes: NONE=0, JUMP=1, BEQZ=2, BNEZ=3, BLTZ=4, BGEZ=5, BSCO=6, identical to the codes the branch-condition evaluator decodes.
  - a flags struct {sf, zf, of, cf}.
- One natural combinational sub-module, flag_alu: op, a, b, cin -> r and flags. The stage module holds the slot, handshake and arch register.

Test Plan:
- Reset, then ADD a=0x7FFF b=0x0001 with flag_we=1, out_ready=1 -> next cycle result=0x8000, sf=1, zf=0, of=1, cf=0; the cycle after, arch_of=1.
- SUB a=0x0005 b=0x0005 -> result=0, zf=1, cf=1, of=0. Then SUB 0x0003-0x0005 -> result=0xFFFE, sf=1, cf=0.
- Back-to-back stream of 4 ops with out_ready=1 -> one result per cycle, in_ready never drops.
- Stall: out_ready=0 for 3 cycles -> in_ready=0 and outputs stable. Then ADDC 0xFFFF+0x0000 with arch_cf=1 -> result=0, cf=1, zf=1.
- Flush with in_valid=1 the same cycle -> out_valid=0 next cycle; arch flags unchanged.
- FLAG_STICKY_OVF_EN: overflow ADD sets ovf_sticky; a following non-overflow op keeps it 1; ovf_clr clears it; set with simultaneous clr -> 1.
